// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D SPI link: frame size, channel numbers,
// sample type and the channel slice helper.
package a2d_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [2:0] CH_LFT_LD  = 3'd0;
    localparam logic [2:0] CH_RGHT_LD = 3'd4;
    localparam logic [2:0] CH_BATT    = 3'd5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef logic [11:0] sample_t;

    function automatic sample_t ch_sel(input logic [95:0] data, input logic [2:0] ch);
        sample_t s;
        s = 12'h000;
        for (int i = 0; i < 8; i++) begin
            if (ch == 3'(i)) begin
                s = data[i*12 +: 12];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SS_n, SCLK and MOSI into clk and derives single-clk edge strobes
// for SS_n and SCLK.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic ss_n_s,
    output logic mosi_s,
    output logic ss_fall,
    output logic ss_rise,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] ss_sync_d, ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_d, sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d, mosi_sync_q;
    logic                   ss_hist_d, ss_hist_q;
    logic                   sclk_hist_d, sclk_hist_q;

    // Next state of the synchronizer chains and history flops
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        ss_hist_d   = ss_sync_q[SYNC_STAGES-1];
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer registers; reset low so no SS_n edge is seen mid-frame after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_hist_q   <= 1'b0;
            sclk_hist_q <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_hist_q   <= ss_hist_d;
            sclk_hist_q <= sclk_hist_d;
        end
    end

    assign ss_n_s    = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ~ss_sync_q[SYNC_STAGES-1] &  ss_hist_q;
    assign ss_rise   =  ss_sync_q[SYNC_STAGES-1] & ~ss_hist_q;
    assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_hist_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling a pipelined ADC: the channel commanded in one frame
// is returned in the next frame, MSB first.
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int FRAME_BITS  = a2d_pkg::FRAME_BITS,
    parameter int CH_MSB      = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [95:0] ch_data,
    output logic        MISO,
    output logic        MISO_oe,
    output logic [2:0]  cmd_ch,
    output logic        cmd_vld,
    output logic        frame_err,
    output logic [11:0] result
);

    localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX   = 5'(FRAME_BITS + 1);

    logic ss_n_s, mosi_s, ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [0:0]            state_d, state_q;
    logic [4:0]            bit_cnt_d, bit_cnt_q;
    logic [15:0]           tx_shft_d, tx_shft_q;
    logic [FRAME_BITS-1:0] rx_shft_d, rx_shft_q;
    logic [2:0]            cmd_ch_d, cmd_ch_q;
    sample_t               result_d, result_q;
    logic                  cmd_vld_d, cmd_vld_q;
    logic                  frame_err_d, frame_err_q;
    logic                  armed_d, armed_q;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n_i   (SS_n),
        .sclk_i   (SCLK),
        .mosi_i   (MOSI),
        .ss_n_s   (ss_n_s),
        .mosi_s   (mosi_s),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall)
    );

    // Frame FSM; SCLK edges are applied before the end-of-frame check so a
    // coincident last edge still counts toward the frame
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shft_d   = tx_shft_q;
        rx_shft_d   = rx_shft_q;
        cmd_ch_d    = cmd_ch_q;
        result_d    = result_q;
        cmd_vld_d   = 1'b0;
        frame_err_d = 1'b0;
        armed_d     = armed_q | ss_n_s;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    tx_shft_d = {4'h0, result_q};
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        bit_cnt_d = CNT_MAX;
                    end
                end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                    tx_shft_d = {tx_shft_q[14:0], 1'b0};
                end else begin
                    tx_shft_d = tx_shft_q;
                end
                if (ss_rise) begin
                    if (bit_cnt_d == CNT_FRAME) begin
                        cmd_ch_d  = rx_shft_d[CH_MSB -: 3];
                        result_d  = ch_sel(ch_data, rx_shft_d[CH_MSB -: 3]);
                        cmd_vld_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            tx_shft_q   <= 16'h0000;
            rx_shft_q   <= '0;
            cmd_ch_q    <= 3'd0;
            result_q    <= 12'h000;
            cmd_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            cmd_ch_q    <= cmd_ch_d;
            result_q    <= result_d;
            cmd_vld_q   <= cmd_vld_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    assign MISO      = (state_q == ST_SHIFT) & tx_shft_q[15];
    assign MISO_oe   = (state_q == ST_SHIFT);
    assign cmd_ch    = cmd_ch_q;
    assign cmd_vld   = cmd_vld_q;
    assign frame_err = frame_err_q;
    assign result    = result_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench: acts as the SPI master and checks returned words, pulses and latched data.
module tb_a2d_spi_resp;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [95:0] ch_data;
    logic        MISO;
    logic        MISO_oe;
    logic [2:0]  cmd_ch;
    logic        cmd_vld;
    logic        frame_err;
    logic [11:0] result;

    int total = 0;
    int bad   = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int exp_vld = 0;
    int exp_err = 0;
    logic        frame_oe;
    logic [31:0] word;

    a2d_spi_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .ch_data  (ch_data),
        .MISO     (MISO),
        .MISO_oe  (MISO_oe),
        .cmd_ch   (cmd_ch),
        .cmd_vld  (cmd_vld),
        .frame_err(frame_err),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_vld === 1'b1) vld_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int n, input logic [11:0] v);
        ch_data[n*12 +: 12] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_oe", 32'(MISO_oe), 32'd0);
        chk("rst_cmd_ch", 32'(cmd_ch), 32'd0);
        chk("rst_vld", 32'(cmd_vld), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // hook 1: reset pulse before bit hook_at; hook 2: change ch5 to 0x222 there
    task automatic frame(input logic [15:0] cmd, input int nbits, input int half,
                         input int gap, input int hook_at, input int hook,
                         output logic [31:0] w);
        logic oe_all;
        logic rst_done;
        oe_all   = 1'b1;
        rst_done = 1'b0;
        w        = 32'h0;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == hook_at && hook == 1) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("midrst_oe", 32'(MISO_oe), 32'd0);
                chk("midrst_miso", 32'(MISO), 32'd0);
                chk("midrst_result", 32'(result), 32'd0);
                chk("midrst_cmd_ch", 32'(cmd_ch), 32'd0);
                rst_n = 1'b1;
                rst_done = 1'b1;
            end
            if (i == hook_at && hook == 2) set_ch(5, 12'h222);
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (half) @(negedge clk);
            w = {w[30:0], MISO};
            if (!rst_done) oe_all = oe_all & MISO_oe;
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (half) @(negedge clk);
        SS_n = 1'b1;
        repeat (gap) @(negedge clk);
        frame_oe = oe_all;
    endtask

    initial begin
        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        ch_data = 96'h0;
        frame_oe = 1'b0;
        word    = 32'h0;

        // First frame after reset returns zero, ch4 becomes the result
        do_reset();
        set_ch(4, 12'h555);
        frame(16'h2000, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("b_word", word, 32'h0000);
        chk("b_oe_in_frame", 32'(frame_oe), 32'd1);
        chk("b_oe_after", 32'(MISO_oe), 32'd0);
        chk("b_result", 32'(result), 32'h555);
        chk("b_cmd_ch", 32'(cmd_ch), 32'd4);
        chk("b_vld_cnt", 32'(vld_cnt), 32'(exp_vld));

        // Pipelined return across three frames; cmd_vld latency 3 clk after SS_n rise
        do_reset();
        set_ch(0, 12'hABC);
        set_ch(5, 12'h7F1);
        frame(16'h0000, 16, 5, 2, -1, 0, word);
        chk("a1_vld_early", 32'(cmd_vld), 32'd0);
        @(negedge clk);
        chk("a1_vld_on_time", 32'(cmd_vld), 32'd1);
        repeat (6) @(negedge clk);
        exp_vld++;
        chk("a1_word", word, 32'h0000);
        chk("a1_cmd_ch", 32'(cmd_ch), 32'd0);
        frame(16'h2800, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("a2_word", word, 32'h0ABC);
        chk("a2_cmd_ch", 32'(cmd_ch), 32'd5);
        frame(16'h0000, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("a3_word", word, 32'h07F1);
        chk("a3_cmd_ch", 32'(cmd_ch), 32'd0);
        chk("a_vld_cnt", 32'(vld_cnt), 32'(exp_vld));

        // Short and long frames flag an error and leave result alone
        set_ch(4, 12'h123);
        frame(16'h2000, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("e0_word", word, 32'h0ABC);
        chk("e0_result", 32'(result), 32'h123);
        frame(16'h0000, 12, 5, 8, -1, 0, word);
        exp_err++;
        chk("e12_word", word, 32'h012);
        chk("e12_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("e12_vld_cnt", 32'(vld_cnt), 32'(exp_vld));
        chk("e12_result", 32'(result), 32'h123);
        chk("e12_cmd_ch", 32'(cmd_ch), 32'd4);
        frame(16'h2000, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("e_next_word", word, 32'h0123);
        frame(16'h0000, 17, 5, 8, -1, 0, word);
        exp_err++;
        chk("e17_word", word, 32'h0246);
        chk("e17_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("e17_vld_cnt", 32'(vld_cnt), 32'(exp_vld));
        chk("e17_result", 32'(result), 32'h123);
        chk("e17_cmd_ch", 32'(cmd_ch), 32'd4);

        // Reset after 8 SCLKs: rest of frame ignored, next frame normal
        set_ch(5, 12'h111);
        frame(16'h2800, 16, 5, 8, 8, 1, word);
        chk("mr_vld_cnt", 32'(vld_cnt), 32'(exp_vld));
        chk("mr_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("mr_result", 32'(result), 32'h000);
        frame(16'h2800, 16, 5, 8, -1, 0, word);
        exp_vld++;
        chk("mr_next_word", word, 32'h0000);
        chk("mr_next_cmd_ch", 32'(cmd_ch), 32'd5);
        chk("mr_next_result", 32'(result), 32'h111);

        // ch5 changes mid-frame; the latched value is what goes out
        frame(16'h0000, 16, 5, 8, 4, 2, word);
        exp_vld++;
        chk("chg_word", word, 32'h0111);

        // Back-to-back frames at clk/8 with a short SS_n high gap
        frame(16'h2000, 16, 4, 4, -1, 0, word);
        exp_vld++;
        chk("bb1_word", word, 32'h0ABC);
        frame(16'h2800, 16, 4, 8, -1, 0, word);
        exp_vld++;
        chk("bb2_word", word, 32'h0123);
        chk("bb_vld_cnt", 32'(vld_cnt), 32'(exp_vld));
        chk("bb_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("bb_cmd_ch", 32'(cmd_ch), 32'd5);
        chk("bb_result", 32'(result), 32'h222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
